// File: rtl/fir_pkg.sv
// Shared FIR widths and the reference requantiser round_sat(), which returns {sat, sample}
// for the default FIR widths in a single combinational call.
package fir_pkg;

  localparam int FIR_IN_W    = 36;
  localparam int FIR_OUT_W   = 16;
  localparam int FIR_Q_SHIFT = 15;

  function automatic logic [FIR_OUT_W:0] round_sat(input logic [FIR_IN_W-1:0] x, input int shift);
    logic signed [FIR_IN_W:0] r;
    logic                     fits;
    logic [FIR_OUT_W-1:0]     sample;
    r      = $signed({x[FIR_IN_W-1], x}) + $signed((FIR_IN_W + 1)'(1) << (shift - 1));
    r      = r >>> shift;
    fits   = (&r[FIR_IN_W:FIR_OUT_W-1]) | ~(|r[FIR_IN_W:FIR_OUT_W-1]);
    sample = fits ? r[FIR_OUT_W-1:0] : {r[FIR_IN_W], {(FIR_OUT_W - 1){~r[FIR_IN_W]}}};
    return {~fits, sample};
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous show-ahead FIFO. The head is a register, so dout holds its last value
// while empty and is zero after reset; a write into an empty FIFO appears one cycle later.
module fir_sample_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] cnt_next;
  logic          do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign rd_next  = rd_ptr + AW'(do_pop);
  assign cnt_next = count + CW'(do_push) - CW'(do_pop);

  // NOTE: storage carries no reset; count and the head register decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_next;
      count  <= cnt_next;
      // The next head is the incoming word when nothing older survives this cycle.
      if (do_push && count == CW'(do_pop))
        dout <= din;
      else if (do_pop && cnt_next != '0)
        dout <= mem[rd_next];
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output stage: round (S1), saturate (S2), then a show-ahead FIFO with advisory in_ready.
// Define FIR_REQUANT_STATS_EN to add the sat_count/drop_count statistics ports.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_IN_W,
  parameter int OUT_W      = FIR_OUT_W,
  parameter int SHIFT      = FIR_Q_SHIFT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sample,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sample,
  output logic             out_sat,
  output logic             overflow,
  input  logic             clear_ovf
`ifdef FIR_REQUANT_STATS_EN
  ,
  output logic [15:0]      sat_count,
  output logic [15:0]      drop_count
`endif
);

  localparam int            CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IN_W:0] RND = (IN_W + 1)'(1) << (SHIFT - 1);

  logic                    s1_valid, s2_valid, s2_sat;
  logic signed [IN_W:0]    s1_sum, s1_r;
  logic [OUT_W-1:0]        s2_sample, s2_sample_d;
  logic                    s2_fits;
  logic [OUT_W:0]          head;
  logic                    fifo_full, fifo_empty, drop;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             occupancy;

  // Sign-extend by one bit so the rounding add cannot wrap.
  assign s1_sum = {in_sample[IN_W-1], in_sample} + RND;

  // r fits OUT_W bits iff every bit from the OUT_W-1 position upward equals the sign.
  assign s2_fits     = (&s1_r[IN_W:OUT_W-1]) | ~(|s1_r[IN_W:OUT_W-1]);
  assign s2_sample_d = s2_fits ? s1_r[OUT_W-1:0] : {s1_r[IN_W], {(OUT_W - 1){~s1_r[IN_W]}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    s1_r      <= s1_sum >>> SHIFT;
    s2_sample <= s2_sample_d;
    s2_sat    <= ~s2_fits;
  end

  fir_sample_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_valid),
    .pop   (out_ready),
    .din   ({s2_sat, s2_sample}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {out_sat, out_sample} = head;
  assign out_valid = ~fifo_empty;

  // A full FIFO still accepts the write when the consumer pops in the same cycle.
  assign drop = s2_valid & fifo_full & ~out_ready;

  // Samples already in flight count against free space so an obedient producer never drops.
  assign occupancy = (CW + 1)'(fifo_count) + (CW + 1)'(s1_valid) + (CW + 1)'(s2_valid);
  assign in_ready  = (occupancy < (CW + 1)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

`ifdef FIR_REQUANT_STATS_EN
  logic sat_write;
  assign sat_write = s2_valid & s2_sat & ~drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else if (clear_ovf) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      if (sat_write && sat_count != 16'hFFFF) sat_count  <= sat_count + 16'd1;
      if (drop && drop_count != 16'hFFFF)     drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
